// File: rtl/cam_pkg.sv
// Shared constants, types and pixel formatting for the OV7670 capture path.
// Pure definitions; no state, no latency, no flow control.
package cam_pkg;
    localparam int c_cam_cols    = 160;
    localparam int c_cam_rows    = 120;
    localparam int c_img_cols    = c_cam_cols / 2;
    localparam int c_img_rows    = c_cam_rows / 2;
    localparam int c_img_pxls    = c_img_cols * c_img_rows;
    localparam int c_nb_img_pxls = 13;
    localparam int c_nb_buf      = 12;
    localparam int c_nb_cnt      = 9;
    localparam int c_bar_len     = 10;

    // rgbfilter bit positions {R,G,B}
    localparam int c_filt_r = 2;
    localparam int c_filt_g = 1;
    localparam int c_filt_b = 0;

    typedef enum logic [1:0] {
        S_WAIT_VS_HI = 2'd0,
        S_WAIT_VS_LO = 2'd1,
        S_CAPTURE    = 2'd2
    } state_t;

    typedef struct packed {
        logic       pclk;
        logic       vsync;
        logic       href;
        logic [7:0] d;
    } cam_bus_t;

    typedef struct packed {
        logic       rgbmode;
        logic       testmode;
        logic [2:0] rgbfilter;
    } mode_t;

    // RGB565: byte0 = R[4:0] G[5:3], byte1 = G[2:0] B[4:0]. YUV422: byte1 carries Y.
    function automatic logic [c_nb_buf-1:0] f_fmt_pixel(
        input logic [7:0] byte0,
        input logic [7:0] byte1,
        input mode_t      mode,
        input logic [2:0] bar
    );
        logic [3:0]          r, g, b;
        logic [c_nb_buf-1:0] pix;
        r = byte0[7:4];
        g = {byte0[2:0], byte1[7]};
        b = byte1[4:1];
        if (mode.testmode) begin
            r = {4{bar[2]}};
            g = {4{bar[1]}};
            b = {4{bar[0]}};
        end
        if (!mode.rgbfilter[c_filt_r]) r = 4'h0;
        if (!mode.rgbfilter[c_filt_g]) g = 4'h0;
        if (!mode.rgbfilter[c_filt_b]) b = 4'h0;
        pix = {r, g, b};
        if (!mode.testmode && !mode.rgbmode) pix = {4'h0, byte1};
        return pix;
    endfunction
endpackage

// File: rtl/cam_fb_writer_if.sv
// Camera input bus, capture mode controls and frame-buffer write port.
// master = writer block, slave = camera/frame-buffer side.
interface cam_fb_writer_if;
    import cam_pkg::*;

    logic                     ov7670_pclk;
    logic                     ov7670_vsync;
    logic                     ov7670_href;
    logic [7:0]               ov7670_d;
    logic                     rgbmode;
    logic                     testmode;
    logic [2:0]               rgbfilter;
    logic                     frame_we;
    logic [c_nb_img_pxls-1:0] frame_addr;
    logic [c_nb_buf-1:0]      frame_pixel;
    logic                     frame_done;

    modport master (
        input  ov7670_pclk, ov7670_vsync, ov7670_href, ov7670_d,
        input  rgbmode, testmode, rgbfilter,
        output frame_we, frame_addr, frame_pixel, frame_done
    );

    modport slave (
        output ov7670_pclk, ov7670_vsync, ov7670_href, ov7670_d,
        output rgbmode, testmode, rgbfilter,
        input  frame_we, frame_addr, frame_pixel, frame_done
    );
endinterface

// File: rtl/cam_sync_edge.sv
// 2-FF synchroniser for the whole camera bundle plus pclk rise / href fall pulses.
// Outputs lag the pins by 2 clk; edge pulses are one clk wide; no backpressure.
module cam_sync_edge
    import cam_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_pclk,
    input  logic       i_vsync,
    input  logic       i_href,
    input  logic [7:0] i_d,
    output logic       o_pclk_rise,
    output logic       o_href_fall,
    output logic       o_vsync,
    output logic       o_href,
    output logic [7:0] o_d
);
    cam_bus_t w_in;
    cam_bus_t r_meta;
    cam_bus_t r_sync;
    logic     r_pclk_d;
    logic     r_href_d;

    // One chain for all bits keeps data aligned with the pclk edge that qualifies it.
    assign w_in = {i_pclk, i_vsync, i_href, i_d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta   <= '0;
            r_sync   <= '0;
            r_pclk_d <= 1'b0;
            r_href_d <= 1'b0;
        end else begin
            r_meta   <= w_in;
            r_sync   <= r_meta;
            r_pclk_d <= r_sync.pclk;
            r_href_d <= r_sync.href;
        end
    end

    assign o_pclk_rise = r_sync.pclk & ~r_pclk_d;
    assign o_href_fall = ~r_sync.href & r_href_d;
    assign o_vsync     = r_sync.vsync;
    assign o_href      = r_sync.href;
    assign o_d         = r_sync.d;
endmodule

// File: rtl/cam_fb_writer.sv
// OV7670 capture: assembles 2-byte pixels, decimates 2x2 and writes 12-bit words to the frame buffer.
// Write strobe 1 clk after the completing synced pclk rise; no backpressure, the buffer always accepts.
module cam_fb_writer
    import cam_pkg::*;
#(
    parameter int P_CAM_COLS = c_cam_cols,
    parameter int P_CAM_ROWS = c_cam_rows,
    parameter int P_IMG_PXLS = c_img_pxls
)(
    input  logic            clk,
    input  logic            rst,
    cam_fb_writer_if.master bus
);
    localparam logic [c_nb_cnt-1:0]      L_CAM_COLS = c_nb_cnt'(P_CAM_COLS);
    localparam logic [c_nb_cnt-1:0]      L_CAM_ROWS = c_nb_cnt'(P_CAM_ROWS);
    localparam logic [c_nb_img_pxls-1:0] L_IMG_PXLS = c_nb_img_pxls'(P_IMG_PXLS);
    localparam logic [3:0]               L_BAR_LAST = 4'(c_bar_len - 1);

    logic       w_pclk_rise;
    logic       w_href_fall;
    logic       w_vsync;
    logic       w_href;
    logic [7:0] w_d;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_frame_start;
    logic   w_frame_end;
    logic   w_capture;
    logic   w_write;

    mode_t                    r_mode;
    logic [c_nb_cnt-1:0]      r_col;
    logic [c_nb_cnt-1:0]      r_row;
    logic                     r_byte_ph;
    logic [7:0]               r_byte0;
    logic [2:0]               r_bar;
    logic [3:0]               r_bar_cnt;
    logic [c_nb_img_pxls-1:0] r_addr;
    logic                     r_we;
    logic [c_nb_buf-1:0]      r_pixel;
    logic                     r_done_pend;
    logic                     r_done;

    cam_sync_edge u_sync (
        .clk         (clk),
        .rst         (rst),
        .i_pclk      (bus.ov7670_pclk),
        .i_vsync     (bus.ov7670_vsync),
        .i_href      (bus.ov7670_href),
        .i_d         (bus.ov7670_d),
        .o_pclk_rise (w_pclk_rise),
        .o_href_fall (w_href_fall),
        .o_vsync     (w_vsync),
        .o_href      (w_href),
        .o_d         (w_d)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        case (r_state)
            S_WAIT_VS_HI: if (w_vsync) w_state_nxt = S_WAIT_VS_LO;
            S_WAIT_VS_LO: if (!w_vsync) begin
                w_state_nxt   = S_CAPTURE;
                w_frame_start = 1'b1;
            end
            S_CAPTURE: if (w_vsync) begin
                w_state_nxt = S_WAIT_VS_LO;
                w_frame_end = 1'b1;
            end
            default: w_state_nxt = S_WAIT_VS_HI;
        endcase
    end

    assign w_capture = (r_state == S_CAPTURE) & w_pclk_rise & w_href;

    // Bounds checks make oversized frames drop pixels instead of wrapping the address.
    assign w_write = w_capture & r_byte_ph & ~r_col[0] & ~r_row[0]
                   & (r_col < L_CAM_COLS) & (r_row < L_CAM_ROWS) & (r_addr < L_IMG_PXLS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_WAIT_VS_HI;
            r_mode      <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_byte_ph   <= 1'b0;
            r_byte0     <= '0;
            r_bar       <= '0;
            r_bar_cnt   <= '0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_pixel     <= '0;
            r_done_pend <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_we        <= w_write;
            r_done_pend <= w_frame_end;
            r_done      <= r_done_pend;
            if (w_write) r_pixel <= f_fmt_pixel(r_byte0, w_d, r_mode, r_bar);
            if (r_we)    r_addr  <= r_addr + 1'b1;

            if (w_frame_start) begin
                r_mode    <= {bus.rgbmode, bus.testmode, bus.rgbfilter};
                r_col     <= '0;
                r_row     <= '0;
                r_byte_ph <= 1'b0;
                r_addr    <= '0;
                r_bar     <= '0;
                r_bar_cnt <= '0;
            end else if (r_state == S_CAPTURE) begin
                if (w_href_fall) begin
                    if (r_row != '1) r_row <= r_row + 1'b1;
                    r_col     <= '0;
                    r_byte_ph <= 1'b0;
                    r_bar     <= '0;
                    r_bar_cnt <= '0;
                end else if (w_capture) begin
                    if (!r_byte_ph) begin
                        r_byte0   <= w_d;
                        r_byte_ph <= 1'b1;
                    end else begin
                        r_byte_ph <= 1'b0;
                        if (r_col != '1) r_col <= r_col + 1'b1;
                    end
                end
                if (w_write) begin
                    if (r_bar_cnt == L_BAR_LAST) begin
                        r_bar_cnt <= '0;
                        r_bar     <= r_bar + 1'b1;
                    end else begin
                        r_bar_cnt <= r_bar_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.frame_we    = r_we;
    assign bus.frame_addr  = r_addr;
    assign bus.frame_pixel = r_pixel;
    assign bus.frame_done  = r_done;
endmodule

// File: tb/tb_cam_fb_writer.sv
// Drives OV7670-style frames on a reduced 32x12 camera geometry and compares every
// frame-buffer write against a reference built from the pixel/decimation rules.
module tb_cam_fb_writer;
    import cam_pkg::*;

    localparam int N_COLS     = 32;
    localparam int N_ROWS     = 12;
    localparam int N_IMG_COLS = N_COLS / 2;
    localparam int N_PXLS     = N_IMG_COLS * (N_ROWS / 2);

    logic clk;
    logic rst;
    cam_fb_writer_if bus();

    cam_fb_writer #(
        .P_CAM_COLS (N_COLS),
        .P_CAM_ROWS (N_ROWS),
        .P_IMG_PXLS (N_PXLS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks;
    int          errors;
    int          done_cnt;
    int          line_idx;
    int          got_addr[$];
    logic [11:0] got_pix[$];
    logic [11:0] exp_pix[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Camera pixel clock: 4 clk periods, phase offset from clk edges.
    initial begin
        bus.ov7670_pclk = 1'b0;
        #3;
        forever #20 bus.ov7670_pclk = ~bus.ov7670_pclk;
    end

    always @(negedge clk) begin
        if (bus.frame_we === 1'b1) begin
            got_addr.push_back(int'(bus.frame_addr));
            got_pix.push_back(bus.frame_pixel);
        end
        if (bus.frame_done === 1'b1) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] model_pixel(input logic [7:0] b0, input logic [7:0] b1,
                                                input bit rgbm, input bit testm,
                                                input logic [2:0] filt, input int k);
        int x0, x1, r, g, b, bar;
        x0 = int'(b0);
        x1 = int'(b1);
        if (!testm && !rgbm) return {4'h0, b1};
        if (testm) begin
            bar = (k / 10) % 8;
            r = ((bar / 4) % 2) * 15;
            g = ((bar / 2) % 2) * 15;
            b = (bar % 2) * 15;
        end else begin
            r = (x0 / 8) / 2;
            g = ((x0 % 8) * 8 + x1 / 32) / 4;
            b = (x1 % 32) / 2;
        end
        if (!filt[2]) r = 0;
        if (!filt[1]) g = 0;
        if (!filt[0]) b = 0;
        return 12'(r * 256 + g * 16 + b);
    endfunction

    function automatic int n_bad_addr();
        int n = 0;
        foreach (got_addr[i]) if (got_addr[i] != i) n++;
        return n;
    endfunction

    function automatic int n_bad_pix();
        int n = 0;
        foreach (got_pix[i]) if (i >= exp_pix.size() || got_pix[i] !== exp_pix[i]) n++;
        return n;
    endfunction

    function automatic int n_not(input logic [11:0] v);
        int n = 0;
        foreach (got_pix[i]) if (got_pix[i] !== v) n++;
        return n;
    endfunction

    task automatic clear_frame();
        got_addr.delete();
        got_pix.delete();
        exp_pix.delete();
        done_cnt = 0;
    endtask

    // kind 0 = constant bytes c0/c1, kind 1 = random bytes. Expected writes are queued as lines are sent.
    task automatic send_frame(input int ppl, input int lines, input bit odd_byte, input int kind,
                              input logic [7:0] c0, input logic [7:0] c1,
                              input bit rgbm, input bit testm, input logic [2:0] filt,
                              input int toggle_line);
        int          written;
        int          k;
        logic [7:0]  b0, b1;
        bus.rgbmode   = rgbm;
        bus.testmode  = testm;
        bus.rgbfilter = filt;
        @(negedge bus.ov7670_pclk);
        bus.ov7670_vsync = 1'b0;
        repeat (4) @(negedge bus.ov7670_pclk);
        written = 0;
        for (int r = 0; r < lines; r++) begin
            line_idx = r;
            if (r == toggle_line) begin
                bus.rgbmode   = ~rgbm;
                bus.testmode  = ~testm;
                bus.rgbfilter = ~filt;
            end
            k = 0;
            for (int c = 0; c < ppl; c++) begin
                b0 = (kind == 1) ? 8'($urandom) : c0;
                b1 = (kind == 1) ? 8'($urandom) : c1;
                @(negedge bus.ov7670_pclk);
                bus.ov7670_href = 1'b1;
                bus.ov7670_d    = b0;
                @(negedge bus.ov7670_pclk);
                bus.ov7670_d    = b1;
                if (c % 2 == 0 && r % 2 == 0 && c < N_COLS && r < N_ROWS && written < N_PXLS) begin
                    exp_pix.push_back(model_pixel(b0, b1, rgbm, testm, filt, k));
                    k++;
                    written++;
                end
            end
            if (odd_byte) begin
                @(negedge bus.ov7670_pclk);
                bus.ov7670_d = 8'($urandom);
            end
            @(negedge bus.ov7670_pclk);
            bus.ov7670_href = 1'b0;
            bus.ov7670_d    = 8'h00;
            repeat (3) @(negedge bus.ov7670_pclk);
        end
        bus.ov7670_vsync = 1'b1;
        repeat (6) @(negedge bus.ov7670_pclk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({bus.frame_we, bus.frame_addr, bus.frame_pixel, bus.frame_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs we=%b addr=%0d pix=%h done=%b want all 0",
                     bus.frame_we, bus.frame_addr, bus.frame_pixel, bus.frame_done);
        end
        rst = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_rgb_const(input logic [2:0] filt, input logic [11:0] want, input string nm);
        clear_frame();
        send_frame(N_COLS, N_ROWS, 1'b0, 0, 8'hF8, 8'h1F, 1'b1, 1'b0, filt, -1);
        checks++;
        if (got_pix.size() !== N_PXLS) begin
            errors++; $display("FAIL %s_count got %0d want %0d", nm, got_pix.size(), N_PXLS);
        end
        checks++;
        if (n_bad_addr() !== 0) begin
            errors++; $display("FAIL %s_addr bad addresses %0d want 0", nm, n_bad_addr());
        end
        checks++;
        if (n_not(want) !== 0) begin
            errors++; $display("FAIL %s_value pixels not %h: %0d want 0 (first %h)", nm, want, n_not(want),
                               got_pix.size() > 0 ? got_pix[0] : 12'hxxx);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL %s_done got %0d pulses want 1", nm, done_cnt);
        end
    endtask

    task automatic test_yuv();
        clear_frame();
        send_frame(N_COLS, N_ROWS, 1'b0, 0, 8'h80, 8'hA5, 1'b0, 1'b0, 3'b000, -1);
        checks++;
        if (got_pix.size() !== N_PXLS) begin
            errors++; $display("FAIL yuv_count got %0d want %0d", got_pix.size(), N_PXLS);
        end
        checks++;
        if (n_not(12'h0A5) !== 0) begin
            errors++; $display("FAIL yuv_value pixels not 0a5: %0d want 0", n_not(12'h0A5));
        end
        checks++;
        if (n_bad_pix() !== 0) begin
            errors++; $display("FAIL yuv_model mismatching pixels %0d want 0", n_bad_pix());
        end
    endtask

    task automatic test_testmode();
        logic [11:0] p10, p16;
        clear_frame();
        send_frame(N_COLS, N_ROWS, 1'b0, 1, 8'h00, 8'h00, 1'($urandom), 1'b1, 3'b111, -1);
        p10 = (got_pix.size() > 16) ? got_pix[10] : 12'hxxx;
        p16 = (got_pix.size() > 16) ? got_pix[16] : 12'hxxx;
        checks++;
        if (got_pix.size() !== N_PXLS) begin
            errors++; $display("FAIL test_count got %0d want %0d", got_pix.size(), N_PXLS);
        end
        checks++;
        if (p10 !== 12'h00F) begin
            errors++; $display("FAIL test_bar1 pixel10 got %h want 00f", p10);
        end
        checks++;
        if (p16 !== 12'h000) begin
            errors++; $display("FAIL test_row_restart pixel16 got %h want 000", p16);
        end
        checks++;
        if (n_bad_pix() !== 0) begin
            errors++; $display("FAIL test_model mismatching pixels %0d want 0", n_bad_pix());
        end
    endtask

    task automatic test_malformed();
        clear_frame();
        send_frame(N_COLS + 4, N_ROWS + 2, 1'b1, 1, 8'h00, 8'h00, 1'b1, 1'b0, 3'b111, 3);
        checks++;
        if (got_pix.size() !== N_PXLS) begin
            errors++; $display("FAIL malformed_count got %0d want %0d", got_pix.size(), N_PXLS);
        end
        checks++;
        if (n_bad_addr() !== 0) begin
            errors++; $display("FAIL malformed_addr bad addresses %0d want 0", n_bad_addr());
        end
        checks++;
        if (n_bad_pix() !== 0) begin
            errors++; $display("FAIL malformed_model mismatching pixels %0d want 0", n_bad_pix());
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL malformed_done got %0d pulses want 1", done_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_frame();
        line_idx = -1;
        fork
            send_frame(N_COLS, N_ROWS, 1'b0, 1, 8'h00, 8'h00, 1'b1, 1'b0, 3'b111, -1);
            begin
                for (int i = 0; i < 20000 && line_idx != 10; i++) @(posedge clk);
                checks++;
                if (line_idx != 10) begin
                    errors++; $display("FAIL midrst_wait line_idx %0d want 10", line_idx);
                end
                repeat (40) @(posedge clk);
                #2 rst = 1'b1;
                #1;
                checks++;
                if ({bus.frame_we, bus.frame_addr, bus.frame_pixel, bus.frame_done} !== '0) begin
                    errors++;
                    $display("FAIL midrst_outputs we=%b addr=%0d pix=%h done=%b want all 0",
                             bus.frame_we, bus.frame_addr, bus.frame_pixel, bus.frame_done);
                end
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
                got_addr.delete();
                got_pix.delete();
                done_cnt = 0;
            end
        join
        checks++;
        if (got_pix.size() !== 0) begin
            errors++; $display("FAIL midrst_no_write got %0d writes want 0", got_pix.size());
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++; $display("FAIL midrst_no_done got %0d pulses want 0", done_cnt);
        end
        clear_frame();
        send_frame(N_COLS, N_ROWS, 1'b0, 1, 8'h00, 8'h00, 1'b1, 1'b0, 3'b111, -1);
        checks++;
        if ((got_addr.size() > 0 ? got_addr[0] : -1) !== 0) begin
            errors++; $display("FAIL midrst_first_addr got %0d want 0", got_addr.size() > 0 ? got_addr[0] : -1);
        end
        checks++;
        if (n_bad_pix() !== 0 || got_pix.size() !== N_PXLS) begin
            errors++; $display("FAIL midrst_refill bad %0d count %0d want 0 and %0d",
                               n_bad_pix(), got_pix.size(), N_PXLS);
        end
    endtask

    task automatic test_random();
        bit          rgbm, testm;
        logic [2:0]  filt;
        for (int f = 0; f < 3; f++) begin
            rgbm  = 1'($urandom);
            testm = ($urandom_range(0, 3) == 0);
            filt  = 3'($urandom);
            clear_frame();
            send_frame(N_COLS, N_ROWS, 1'($urandom), 1, 8'h00, 8'h00, rgbm, testm, filt, -1);
            checks++;
            if (got_pix.size() !== N_PXLS || n_bad_addr() !== 0) begin
                errors++; $display("FAIL rand%0d_seq count %0d bad_addr %0d want %0d and 0",
                                   f, got_pix.size(), n_bad_addr(), N_PXLS);
            end
            checks++;
            if (n_bad_pix() !== 0) begin
                errors++; $display("FAIL rand%0d_model rgb=%0d test=%0d filt=%b mismatching %0d want 0",
                                   f, rgbm, testm, filt, n_bad_pix());
            end
            checks++;
            if (done_cnt !== 1) begin
                errors++; $display("FAIL rand%0d_done got %0d pulses want 1", f, done_cnt);
            end
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        done_cnt         = 0;
        line_idx         = -1;
        bus.ov7670_vsync = 1'b1;
        bus.ov7670_href  = 1'b0;
        bus.ov7670_d     = 8'h00;
        bus.rgbmode      = 1'b0;
        bus.testmode     = 1'b0;
        bus.rgbfilter    = 3'b000;
        test_reset();
        test_rgb_const(3'b111, 12'hF0F, "rgb_full");
        test_rgb_const(3'b011, 12'h00F, "rgb_filt");
        test_yuv();
        test_testmode();
        test_malformed();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
